bist_scan_ctrl: RTL
===================

# bist_scan_ctrl

Self-test controller sitting directly around the scan-equipped control FSM block. It drives that block's scan chain and primary inputs and consumes its scan output and primary outputs. A 16-bit LFSR generates pseudo-random patterns, a sequencer alternates scan-shift and single-cycle capture, and a 16-bit MISR compacts all responses into a signature. The signature is compared to a golden value to give a pass/fail verdict.

## Interface
- CHAIN_LEN, 12: number of scan flops in the target chain.
- NUM_PATTERNS, 64: number of capture cycles per run (≥1).
- LFSR_SEED, 16'hACE1: LFSR load value at start; must be nonzero.
- MISR_SEED, 16'h0000: MISR load value at start.
- GOLDEN, 16'h0000: expected final signature.

- clock  in  1  system clock, rising edge.
- reset  in  1  reset, synchronous, active-high; clock clock.
- start  in  1  run request, sampled in IDLE/DONE only.
- busy  out  1  high in SHIFT, CAPTURE, FLUSH.
- done  out  1  high in DONE.
- pass  out  1  valid while done: signature == GOLDEN; 0 otherwise.
- signature  out  16  current MISR contents.
- scan_en  out  1  to target scan enable.
- scan_in  out  1  to target scan input.
- scan_out  in  1  from target scan output.
- pi  out  5  to target {s, dv, l_in, test_in[1:0]}.
- po  in  9  from target {fz_L, lclk, read_a[4:0], test_out[1:0]}.

## Operation
- States: IDLE, SHIFT, CAPTURE, FLUSH, DONE.
- Reset: state IDLE; busy=0, done=0, pass=0, scan_en=0, scan_in=0, pi=0; signature=MISR_SEED; LFSR=LFSR_SEED; counters 0.
- IDLE/DONE + start=1 → SHIFT:
  - reload LFSR=LFSR_SEED and MISR=MISR_SEED;
  - clear bit and pattern counters;
  - done drops.
- SHIFT, CHAIN_LEN cycles:
  - scan_en=1, scan_in=lfsr[15], pi=0;
  - LFSR steps each cycle;
  - MISR absorbs {15'b0, scan_out} each cycle;
  - after the last shift cycle → CAPTURE.
- CAPTURE, 1 cycle:
  - scan_en=0, pi=lfsr[4:0], scan_in=0;
  - LFSR steps;
  - MISR absorbs {7'b0, po}, see Configuration;
  - pattern counter increments;
  - if the count reaches NUM_PATTERNS → FLUSH, else → SHIFT.
- FLUSH, CHAIN_LEN cycles: same as SHIFT, unloads the last capture. Then → DONE.
- DONE: done=1, pass=(signature==GOLDEN). Holds until start or reset.
- start while busy: ignored.
- LFSR step: lfsr ← {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
- MISR step: misr ← {misr[14:0], misr[15]^misr[13]^misr[12]^misr[10]} ^ data.
- Counters:
  - bit counter is $clog2(CHAIN_LEN+1) bits and counts 0..CHAIN_LEN-1;
  - pattern counter is $clog2(NUM_PATTERNS+1) bits;
  - no wrap within a run.
- First SHIFT unloads the target's reset state; it is compacted like any other data.

## Timing
- All outputs are registered, except pass, which is combinational from registered signature and state.
- start sampled at edge T: the first SHIFT cycle is T+1.
- Run length is NUM_PATTERNS·(CHAIN_LEN+1)+CHAIN_LEN cycles with busy=1. Default: 844.
- done rises at the edge ending the last FLUSH cycle.
- scan_en profile per pattern: CHAIN_LEN cycles high, 1 cycle low. The FLUSH tail stays high.
- MISR samples scan_out/po in the same cycle scan_en/pi are presented. The target updates on that same edge, so each response is seen one cycle after its stimulus.
- Reset mid-run: next cycle is IDLE with all reset values; partial signature discarded.
- start and reset together: reset wins.

## Configuration
- BIST_PO_COMPACT_EN defined:
  - CAPTURE data word = {7'b0, po};
  - primary outputs are covered.
- Undefined:
  - CAPTURE data word = 16'h0000;
  - the MISR still steps with zero data, so cycle count and state sequence are identical;
  - po is unused;
  - GOLDEN must match the build.

## Test plan
- Reset held 3 cycles → busy=0, done=0, pass=0, scan_en=0, pi=0, signature=16'h0000.
- start pulse, defaults, target attached → busy high exactly 844 cycles; scan_en pattern 12×1, 1×0 repeated 64 times then 12×1; done=1 afterwards; signature equals the reference-model value; pass=1 with GOLDEN set to it.
- Same run with scan_out forced 0 → signature differs from fault-free value; pass=0.
- start re-pulsed at cycle 100 of a run → ignored; completes at cycle 844 with the same signature.
- reset asserted at cycle 400 → IDLE next cycle, busy=0; a fresh start then reproduces the fault-free signature.
- With BIST_PO_COMPACT_EN undefined, toggle po randomly → signature unchanged versus po held 0. With it defined → signature changes.

Source files
------------

// File: rtl/bist_scan_ctrl.sv
// bist_scan_ctrl: logic BIST controller wrapped around a scan-equipped target.
// A 16-bit LFSR feeds the scan chain and primary inputs; a 16-bit MISR
// compacts the scan-out stream (and optionally the primary outputs).
// Optional feature macro: BIST_PO_COMPACT_EN (compact po during CAPTURE).
module bist_scan_ctrl #(
    parameter int unsigned CHAIN_LEN    = 12,
    parameter int unsigned NUM_PATTERNS = 64,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter logic [15:0] MISR_SEED    = 16'h0000,
    parameter logic [15:0] GOLDEN       = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature,
    output logic        scan_en,
    output logic        scan_in,
    input  logic        scan_out,
    output logic [4:0]  pi,
    input  logic [8:0]  po
);

    localparam int unsigned BW = $clog2(CHAIN_LEN + 1);
    localparam int unsigned PW = $clog2(NUM_PATTERNS + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(CHAIN_LEN - 1);
    localparam logic [PW-1:0] PAT_LAST = PW'(NUM_PATTERNS - 1);

    typedef enum logic [2:0] {IDLE, SHIFT, CAPTURE, FLUSH, DONE} state_t;

    state_t        state;
    logic [15:0]   lfsr;
    logic [15:0]   lfsr_nxt;
    logic [15:0]   cap_data;
    logic [BW-1:0] bit_cnt;
    logic [PW-1:0] pat_cnt;

    // Shared feedback polynomial for both the LFSR and the MISR shift.
    function automatic logic [15:0] fb_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    assign lfsr_nxt = fb_step(lfsr);

`ifdef BIST_PO_COMPACT_EN
    assign cap_data = {7'b0, po};
`else
    // Capture still clocks the MISR, with zero data, so timing is build-independent.
    assign cap_data = 16'h0000;
    logic unused_po;
    assign unused_po = ^po;
`endif

    // Verdict is only meaningful once the run has completed.
    assign pass = (state == DONE) && (signature == GOLDEN);

    // Sequencer, pattern generator and response compactor; outputs are
    // loaded with the values belonging to the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            scan_en   <= 1'b0;
            scan_in   <= 1'b0;
            pi        <= '0;
            signature <= MISR_SEED;
            lfsr      <= LFSR_SEED;
            bit_cnt   <= '0;
            pat_cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= SHIFT;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        scan_en   <= 1'b1;
                        scan_in   <= LFSR_SEED[15];
                        pi        <= '0;
                        lfsr      <= LFSR_SEED;
                        signature <= MISR_SEED;
                        bit_cnt   <= '0;
                        pat_cnt   <= '0;
                    end
                end
                SHIFT, FLUSH: begin
                    signature <= fb_step(signature) ^ {15'b0, scan_out};
                    lfsr      <= lfsr_nxt;
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        scan_en <= 1'b0;
                        scan_in <= 1'b0;
                        if (state == SHIFT) begin
                            state <= CAPTURE;
                            pi    <= lfsr_nxt[4:0];
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                        scan_in <= lfsr_nxt[15];
                    end
                end
                CAPTURE: begin
                    signature <= fb_step(signature) ^ cap_data;
                    lfsr      <= lfsr_nxt;
                    pi        <= '0;
                    scan_en   <= 1'b1;
                    scan_in   <= lfsr_nxt[15];
                    pat_cnt   <= pat_cnt + PW'(1);
                    state     <= (pat_cnt == PAT_LAST) ? FLUSH : SHIFT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
